// File: rtl/shift_pkg.sv
// shift_pkg: shared operation encodings for universal_shift and its controllers.
// Contents: MODE_* constants for the 2-bit mode select, plus a mode type alias.
// Drivers of `mode` should use these names rather than raw literals.
package shift_pkg;

  typedef logic [1:0] shift_mode_t;

  localparam shift_mode_t MODE_HOLD = 2'b00;
  localparam shift_mode_t MODE_SHR  = 2'b01;
  localparam shift_mode_t MODE_SHL  = 2'b10;
  localparam shift_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_counter.sv
// shift_counter: modulo-WIDTH shift counter that flags the WIDTH-th shift.
// Ports: clk, clear (async active-high), inc (a shift happens this edge),
//        rst_cnt (synchronous return to 0, wins over inc), wrap (comb: inc at count WIDTH-1).
module shift_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic inc,
  input  logic rst_cnt,
  output logic wrap
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  // Wrap is combinational so the top can register the strobe on the same edge
  // that returns the count to zero.
  assign wrap = inc && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (rst_cnt) begin
      cnt_d = '0;
    end else if (inc) begin
      // Explicit wrap keeps non-power-of-two widths modulo WIDTH.
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/universal_shift.sv
// universal_shift: WIDTH-bit hold / shift right / shift left / load register with rotate.
// Ports: clk, clear (async active-high), mode, rotate, si_r, si_l, D in;
//        A (contents), so_r = A[0], so_l = A[WIDTH-1], frame_done (one-cycle strobe per WIDTH shifts).
module universal_shift
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] A,
  output logic             so_r,
  output logic             so_l,
  output logic             frame_done
);

  logic [WIDTH-1:0] a_d, a_q;
  logic             frame_done_d, frame_done_q;
  logic             shift_en;
  logic             load_en;
  logic             wrap;

  always_comb begin
    a_d      = a_q;
    shift_en = 1'b0;
    load_en  = 1'b0;
    case (mode)
      MODE_SHR: begin
        a_d      = {(rotate ? a_q[0] : si_r), a_q[WIDTH-1:1]};
        shift_en = 1'b1;
      end
      MODE_SHL: begin
        a_d      = {a_q[WIDTH-2:0], (rotate ? a_q[WIDTH-1] : si_l)};
        shift_en = 1'b1;
      end
      MODE_LOAD: begin
        a_d     = D;
        load_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  shift_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .clear   (clear),
    .inc     (shift_en),
    .rst_cnt (load_en),
    .wrap    (wrap)
  );

  // wrap is only ever high on a shift edge, so hold and load drop the strobe.
  assign frame_done_d = wrap;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      a_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      a_q          <= a_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign A          = a_q;
  assign so_r       = a_q[0];
  assign so_l       = a_q[WIDTH-1];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_universal_shift.sv
// tb_universal_shift: directed vectors for WIDTH=4 and WIDTH=8 instances.
// The driver pushes hand-computed post-edge expectations; a monitor pops and compares after each edge.
// Asynchronous clear effects are checked directly between edges.
module tb_universal_shift;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       clear = 1'b1;

  logic [1:0] m4 = MODE_HOLD, m8 = MODE_HOLD;
  logic       rot4 = 1'b0, rot8 = 1'b0;
  logic       si4 = 1'b0, si8 = 1'b0;
  logic [3:0] d4 = '0;
  logic [7:0] d8 = '0;
  logic [3:0] a4;
  logic [7:0] a8;
  logic       sor4, sol4, fd4, sor8, sol8, fd8;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       sel;
    logic [7:0] a;
    logic       fd;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  universal_shift #(.WIDTH(4)) u_dut4 (
    .clk(clk), .clear(clear), .mode(m4), .rotate(rot4), .si_r(si4), .si_l(si4),
    .D(d4), .A(a4), .so_r(sor4), .so_l(sol4), .frame_done(fd4)
  );

  universal_shift #(.WIDTH(8)) u_dut8 (
    .clk(clk), .clear(clear), .mode(m8), .rotate(rot8), .si_r(si8), .si_l(si8),
    .D(d8), .A(a8), .so_r(sor8), .so_l(sol8), .frame_done(fd8)
  );

  // Word layout: {frame_done, so_l, so_r, A}
  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got fd/so_l/so_r/A=%b/%b/%b/%b expected %b/%b/%b/%b",
               nm, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Monitor: every edge with a pending expectation is compared 1 time unit later.
  always @(posedge clk) begin
    exp_t        e;
    string       nm;
    logic [10:0] act, exp;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.sel == 1'b0) begin
        act = {fd4, sol4, sor4, 4'b0000, a4};
        exp = {e.fd, e.a[3], e.a[0], e.a};
      end else begin
        act = {fd8, sol8, sor8, a8};
        exp = {e.fd, e.a[7], e.a[0], e.a};
      end
      check(nm, act, exp);
    end
  end

  // Drive one edge on the selected instance (other one holds) and queue its expected result.
  task automatic step(input logic sel, input logic [1:0] m, input logic rot, input logic si,
                      input logic [7:0] d, input logic [7:0] ea, input logic efd, input string nm);
    exp_t e;
    @(negedge clk);
    if (sel == 1'b0) begin
      m4 = m; rot4 = rot; si4 = si; d4 = d[3:0]; m8 = MODE_HOLD;
    end else begin
      m8 = m; rot8 = rot; si8 = si; d8 = d; m4 = MODE_HOLD;
    end
    e.sel = sel; e.a = ea; e.fd = efd;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic s4(input logic [1:0] m, input logic rot, input logic si, input logic [3:0] d,
                    input logic [3:0] ea, input logic efd, input string nm);
    step(1'b0, m, rot, si, {4'b0000, d}, {4'b0000, ea}, efd, nm);
  endtask

  logic [7:0] alt_a[8] = '{8'h00, 8'h80, 8'h40, 8'hA0, 8'h50, 8'hA8, 8'h54, 8'hAA};

  initial begin
    // Reset state while clear is asserted.
    #3;
    check("reset4", {fd4, sol4, sor4, 4'b0000, a4}, 11'b0);
    check("reset8", {fd8, sol8, sor8, a8}, 11'b0);
    @(negedge clk);
    clear = 1'b0;

    // Serial-to-parallel, shift right with si_r=1.
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1000, 1'b0, "s2p_1");
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1100, 1'b0, "s2p_2");
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1110, 1'b0, "s2p_3");
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1111, 1'b1, "s2p_4_frame");
    s4(MODE_HOLD, 1'b0, 1'b0, 4'h0, 4'b1111, 1'b0, "s2p_hold");

    // Load then rotate left; so_l=1 before the first rotate edge.
    s4(MODE_LOAD, 1'b1, 1'b1, 4'b1010, 4'b1010, 1'b0, "load_1010");
    s4(MODE_SHL, 1'b1, 1'b0, 4'h0, 4'b0101, 1'b0, "rotl_1");
    s4(MODE_SHL, 1'b1, 1'b0, 4'h0, 4'b1010, 1'b0, "rotl_2");

    // Shift left with serial out; load restarts the frame count.
    s4(MODE_LOAD, 1'b0, 1'b0, 4'b1011, 4'b1011, 1'b0, "load_1011");
    s4(MODE_SHL, 1'b0, 1'b0, 4'h0, 4'b0110, 1'b0, "shl_1");
    s4(MODE_SHL, 1'b0, 1'b0, 4'h0, 4'b1100, 1'b0, "shl_2");
    s4(MODE_SHL, 1'b0, 1'b0, 4'h0, 4'b1000, 1'b0, "shl_3");
    s4(MODE_SHL, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b1, "shl_4_frame");

    // Asynchronous clear between edges after two shifts.
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1000, 1'b0, "pre_clr_1");
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1100, 1'b0, "pre_clr_2");
    @(negedge clk);
    m4 = MODE_HOLD;
    #2 clear = 1'b1;
    #1 check("async_clear", {fd4, sol4, sor4, 4'b0000, a4}, 11'b0);
    @(negedge clk);
    clear = 1'b0;
    s4(MODE_SHR, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, "post_clr_1");
    s4(MODE_SHR, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, "post_clr_2");
    s4(MODE_SHR, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, "post_clr_3");
    s4(MODE_SHR, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b1, "post_clr_4_frame");

    // Load mid-frame restarts the count: 3 shifts, load, 1 shift -> no strobe.
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1000, 1'b0, "ld_mid_1");
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1100, 1'b0, "ld_mid_2");
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1110, 1'b0, "ld_mid_3");
    s4(MODE_LOAD, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, "ld_mid_load");
    s4(MODE_SHR, 1'b1, 1'b0, 4'h0, 4'b1000, 1'b0, "ld_mid_rotr");

    // Holds do not disturb the count: load, 3 shifts, 5 holds, 1 shift -> strobe.
    s4(MODE_LOAD, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, "hold_load");
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1000, 1'b0, "hold_sh1");
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1100, 1'b0, "hold_sh2");
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1110, 1'b0, "hold_sh3");
    for (int i = 0; i < 5; i++)
      s4(MODE_HOLD, 1'b0, 1'b1, 4'h0, 4'b1110, 1'b0, "hold_idle");
    s4(MODE_SHR, 1'b0, 1'b1, 4'h0, 4'b1111, 1'b1, "hold_sh4_frame");
    s4(MODE_HOLD, 1'b0, 1'b0, 4'h0, 4'b1111, 1'b0, "hold_after");

    // WIDTH=8 serial-to-parallel with alternating si_r (0 first).
    @(negedge clk);
    m4 = MODE_HOLD; m8 = MODE_HOLD;
    clear = 1'b1;
    #1 check("reset8_again", {fd8, sol8, sor8, a8}, 11'b0);
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 8; i++)
      step(1'b1, MODE_SHR, 1'b0, logic'(i % 2), 8'h00, alt_a[i], (i == 7), "w8_shift");
    step(1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00, 8'hAA, 1'b0, "w8_hold");

    // Let the monitor drain, then confirm nothing was left uncompared.
    @(negedge clk);
    m4 = MODE_HOLD; m8 = MODE_HOLD;
    repeat (3) @(negedge clk);
    check("queue_drained", 11'(exp_q.size()), 11'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/universal_shift.md
# universal_shift

Parametrised universal shift register for the Registers library; it is the generalised successor to the fixed 4-bit serial-in register. It adds bidirectional shifting, rotate, parallel load and hold, plus a shift counter that strobes `frame_done` after every WIDTH shifts. This lets the block serve directly as a serial-to-parallel or parallel-to-serial converter.

## Interface
- `WIDTH`, default 4: register width in bits, minimum 2.
- `clk`  input  1: rising-edge clock.
- `clear`  input  1: asynchronous, active-high reset.
- `mode`  input  2: operation select. 00 = hold, 01 = shift right, 10 = shift left, 11 = parallel load.
- `rotate`  input  1: when 1, shift modes wrap the outgoing bit instead of taking the serial input.
- `si_r`  input  1: serial input for shift right; enters the MSB.
- `si_l`  input  1: serial input for shift left; enters the LSB.
- `D`  input  WIDTH: parallel load data.
- `A`  output  WIDTH: register contents.
- `so_r`  output  1: right serial out. Combinational, equal to `A[0]`.
- `so_l`  output  1: left serial out. Combinational, equal to `A[WIDTH-1]`.
- `frame_done`  output  1: registered one-cycle strobe after every WIDTH-th shift.

## Operation
- Reset value: while `clear`=1, `A`=0, the internal counter `cnt`=0 and `frame_done`=0. `so_r`=`so_l`=0 as a consequence.
- Hold (00): `A` and `cnt` keep their values; `frame_done` is 0 on the next edge.
- Shift right (01): `A <= {in, A[WIDTH-1:1]}`. `in` is `A[0]` when `rotate`=1, otherwise `si_r`.
- Shift left (10): `A <= {A[WIDTH-2:0], in}`. `in` is `A[WIDTH-1]` when `rotate`=1, otherwise `si_l`.
- Load (11): `A <= D`, `cnt <= 0`, `frame_done <= 0`. `rotate`, `si_r` and `si_l` are ignored.
- Counter: `cnt` is a modulo-WIDTH counter of width clog2(WIDTH).
  - Every shift edge in either direction, with or without rotate, increments `cnt`.
  - When a shift occurs with `cnt`=WIDTH-1, `cnt` wraps to 0 and `frame_done <= 1`.
  - Every other edge sets `frame_done <= 0`, so the strobe is never longer than one cycle.
- Direction changes mid-frame do not reset `cnt`; only load and `clear` do.
- `rotate` changes take effect on the same edge, with no pipeline.
- `clear` mid-operation aborts any partial frame. The next `frame_done` requires WIDTH further shifts after `clear` deasserts.

## Timing
- Single clock domain, all state updates on the rising edge of `clk`.
- `clear` acts immediately, independent of `clk`, and dominates every other input. Release is synchronous to the next rising edge; the first edge with `clear`=0 performs the selected mode.
- Latency is one cycle from `mode`/`D` to `A`.
- `so_r` and `so_l` follow `A` combinationally, so they show the bit about to be shifted out before the edge.
- `frame_done` is high for exactly the cycle following the WIDTH-th shift edge. With continuous shifting it is high every WIDTH cycles.
- Inputs must be stable around the rising edge of `clk`; no input registering is performed.

## Structure
- A shared package `shift_pkg` holds the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD, so that controllers driving `mode` use the same constants.
- One sub-module, `shift_counter`. It is the modulo-WIDTH counter with `clk`, `clear`, `inc`, `rst_cnt` inputs and a `wrap` output.
  - The top level registers `frame_done` from `wrap`.
  - The data path (the four-way mux and `A` register) stays in the top module.

## Test plan
- Serial-to-parallel: pulse `clear`, then apply `mode`=01, `rotate`=0, `si_r`=1 for 4 edges.
  - Required: `A` steps 1000, 1100, 1110, 1111.
  - `frame_done`=1 only in the cycle after the 4th edge, then 0 on a following hold.
- Load and rotate: `mode`=11 with `D`=1010 gives `A`=1010 and `cnt`=0.
  - Then `mode`=10, `rotate`=1 for 2 edges gives `A`=0101, then 1010.
  - `so_l` reads 1 before the first rotate edge.
- Shift left with serial out: load 1011, then `mode`=10, `si_l`=0.
  - Required: `A`=0110 and `so_l`=0 after the edge.
  - 3 more shifts give 0000, with `frame_done` strobing after the 4th shift.
- Asynchronous `clear` mid-frame: after 2 shifts, raise `clear` between clock edges.
  - Required: `A`=0000 immediately, not at the next edge.
  - After release, `frame_done` stays 0 until 4 further shifts.
- Load and hold versus counter: 3 shifts, then 1 load, then 1 shift gives no `frame_done`.
  - 3 shifts, then 5 holds, then 1 shift gives `frame_done`=1.
- Width sweep: repeat the first scenario with `WIDTH`=8 and alternating `si_r`.
  - Required: `A`=10101010 (last bit in at the MSB) and `frame_done` after the 8th edge.
